// File: rtl/sal_act_pkg.sv
// sal_act_pkg: definitions shared by the ACT arbiter and its round-robin picker.
//   act_state_e   : arbiter FSM state (idle / holding an offered ACT)
//   FAW_ACT_LIMIT : number of ACTs allowed inside one tFAW window
//   sat_sub2()    : max(v - 2, 0) for timer reload values
package sal_act_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } act_state_e;

    localparam int unsigned FAW_ACT_LIMIT = 4;

    // Timers reload with (period - 2): one cycle is spent in IDLE deciding and one
    // registering act_valid, so a reload of N gives handshakes N + 2 cycles apart.
    function automatic logic [5:0] sat_sub2(input logic [5:0] v);
        return (v > 6'd2) ? (v - 6'd2) : 6'd0;
    endfunction

endpackage

// File: rtl/sal_rr_arb.sv
// sal_rr_arb: purely combinational round-robin pick.
// Search order is ptr, ptr+1, ... wrapping modulo BK_CNT (BK_CNT is a power of two,
// so the wrap is plain BK_BW-bit overflow).
//   req   : per-bank request vector
//   ptr   : highest-priority bank index
//   valid : any request present
//   index : first requesting bank in search order (0 when valid is low)
module sal_rr_arb #(
    parameter int unsigned BK_CNT = 4,
    parameter int unsigned BK_BW  = $clog2(BK_CNT)
) (
    input  logic [BK_CNT-1:0] req,
    input  logic [BK_BW-1:0]  ptr,
    output logic              valid,
    output logic [BK_BW-1:0]  index
);

    logic [BK_BW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = 0; i < int'(BK_CNT); i++) begin
            cand = ptr + BK_BW'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/sal_act_arb.sv
// sal_act_arb: round-robin arbiter issuing bank ACT commands under tRRD and tFAW.
// A winner is registered in IDLE and offered (act_valid_o/act_bk_o) until the command
// bus accepts it; the accepted bank receives a one-cycle combinational grant.
// Optional feature: define SAL_ACT_ARB_FAW_EN to build four tFAW slot timers; without
// it tfaw_i is ignored and the tFAW window never stalls.
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   req_i        : per-bank ACT request, level, held until granted
//   trrd_i       : tRRD in cycles (quasi-static)
//   tfaw_i       : tFAW in cycles (quasi-static)
//   act_valid_o  : ACT offered to the command bus
//   act_bk_o     : bank index of the offered ACT
//   act_ready_i  : command bus accepts the ACT
//   gnt_o        : one-hot grant pulse in the handshake cycle
module sal_act_arb
    import sal_act_pkg::*;
#(
    parameter int unsigned BK_CNT = 4,
    parameter int unsigned BK_BW  = $clog2(BK_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BK_CNT-1:0] req_i,
    input  logic [3:0]        trrd_i,
    input  logic [5:0]        tfaw_i,
    output logic              act_valid_o,
    output logic [BK_BW-1:0]  act_bk_o,
    input  logic              act_ready_i,
    output logic [BK_CNT-1:0] gnt_o
);

    act_state_e       state_q, state_d;
    logic             act_valid_q, act_valid_d;
    logic [BK_BW-1:0] act_bk_q, act_bk_d;
    logic [BK_BW-1:0] ptr_q, ptr_d;
    logic [3:0]       trrd_cnt_q, trrd_cnt_d;
    logic [3:0]       trrd_load;
    logic             rr_valid;
    logic [BK_BW-1:0] rr_index;
    logic             hs;
    logic             faw_free;

    // act_valid_q is only ever set in HOLD, so ready while idle is ignored here.
    assign hs        = act_valid_q & act_ready_i;
    assign trrd_load = (trrd_i > 4'd2) ? (trrd_i - 4'd2) : 4'd0;

    sal_rr_arb #(
        .BK_CNT (BK_CNT),
        .BK_BW  (BK_BW)
    ) u_rr_arb (
        .req   (req_i),
        .ptr   (ptr_q),
        .valid (rr_valid),
        .index (rr_index)
    );

    always_comb begin
        state_d     = state_q;
        act_valid_d = act_valid_q;
        act_bk_d    = act_bk_q;
        ptr_d       = ptr_q;
        trrd_cnt_d  = (trrd_cnt_q != 4'd0) ? (trrd_cnt_q - 4'd1) : 4'd0;
        unique case (state_q)
            StIdle: begin
                if (rr_valid && (trrd_cnt_q == 4'd0) && faw_free) begin
                    state_d     = StHold;
                    act_valid_d = 1'b1;
                    act_bk_d    = rr_index;
                end
            end
            StHold: begin
                // Offer stays frozen even if the bank drops its request.
                if (hs) begin
                    state_d     = StIdle;
                    act_valid_d = 1'b0;
                    ptr_d       = act_bk_q + BK_BW'(1);
                    trrd_cnt_d  = trrd_load;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_o = '0;
        if (hs) begin
            gnt_o[act_bk_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            act_valid_q <= 1'b0;
            act_bk_q    <= '0;
            ptr_q       <= '0;
            trrd_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            act_valid_q <= act_valid_d;
            act_bk_q    <= act_bk_d;
            ptr_q       <= ptr_d;
            trrd_cnt_q  <= trrd_cnt_d;
        end
    end

`ifdef SAL_ACT_ARB_FAW_EN
    logic [5:0] faw_cnt_q [FAW_ACT_LIMIT];
    logic [5:0] faw_cnt_d [FAW_ACT_LIMIT];
    logic [5:0] tfaw_load;
    logic       faw_loaded;

    assign tfaw_load = sat_sub2(tfaw_i);

    // A slot at zero is free. Entering HOLD requires a free slot, and counters only
    // count down, so that slot is still free when the handshake loads it.
    always_comb begin
        faw_free   = 1'b0;
        faw_loaded = 1'b0;
        for (int s = 0; s < int'(FAW_ACT_LIMIT); s++) begin
            faw_cnt_d[s] = (faw_cnt_q[s] != 6'd0) ? (faw_cnt_q[s] - 6'd1) : 6'd0;
            if (faw_cnt_q[s] == 6'd0) begin
                faw_free = 1'b1;
                if (hs && !faw_loaded) begin
                    faw_cnt_d[s] = tfaw_load;
                    faw_loaded   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(FAW_ACT_LIMIT); s++) begin
                faw_cnt_q[s] <= 6'd0;
            end
        end else begin
            for (int s = 0; s < int'(FAW_ACT_LIMIT); s++) begin
                faw_cnt_q[s] <= faw_cnt_d[s];
            end
        end
    end
`else
    logic unused_tfaw;

    assign unused_tfaw = ^tfaw_i;
    assign faw_free    = 1'b1;
`endif

    assign act_valid_o = act_valid_q;
    assign act_bk_o    = act_bk_q;

endmodule

// File: doc/sal_act_arb.md
SAL_ACT_ARB -- requirements
Module: SAL_ACT_ARB

Interface
REQ-001 SHALL have parameter BK_CNT, default 4, meaning number of bank requesters (power of two, 2..16).
REQ-002 SHALL have parameter BK_BW, default $clog2(BK_CNT), meaning bank index width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port req_i  input  BK_CNT  per-bank ACT request, level, held until granted.
REQ-006 SHALL have port trrd_i  input  4  tRRD in cycles, quasi-static.
REQ-007 SHALL have port tfaw_i  input  6  tFAW in cycles, quasi-static.
REQ-008 SHALL have port act_valid_o  output  1  ACT command valid toward command bus.
REQ-009 SHALL have port act_bk_o  output  BK_BW  bank index of offered ACT.
REQ-010 SHALL have port act_ready_i  input  1  command bus accepts ACT.
REQ-011 SHALL have port gnt_o  output  BK_CNT  one-hot, one-cycle grant pulse to the accepted bank.

Function
REQ-012 SHALL implement FSM IDLE/HOLD; handshake = act_valid_o & act_ready_i.
REQ-013 IDLE->HOLD SHALL occur when |req_i, tRRD counter == 0 and a tFAW slot is free; otherwise SHALL stay IDLE.
REQ-014 On IDLE->HOLD, SHALL register the round-robin winner into act_bk_o; act_valid_o (registered) SHALL rise the next cycle.
REQ-015 In HOLD, act_valid_o and act_bk_o SHALL stay stable until handshake, even if req_i of that bank drops.
REQ-016 On handshake, SHALL go HOLD->IDLE, deassert act_valid_o next cycle, pulse gnt_o[act_bk_o] combinationally in the handshake cycle.
REQ-017 Round-robin: pointer starts at bank 0; search order ptr, ptr+1, ... mod BK_CNT; after handshake of bank k, ptr = (k+1) mod BK_CNT.
REQ-018 tRRD counter SHALL load max(trrd_i-2,0) on handshake and decrement to saturate at 0; consecutive handshakes SHALL be >= max(trrd_i,2) cycles apart.
REQ-019 act_ready_i while act_valid_o == 0 SHALL be ignored.
REQ-020 gnt_o SHALL be all-zero outside handshake cycles; never more than one bit set.

Reset
REQ-021 Reset SHALL force IDLE, act_valid_o=0, act_bk_o=0, gnt_o=0, ptr=0, all counters 0, all tFAW slots free.
REQ-022 Reset asserted in HOLD SHALL drop the pending ACT with no grant; no state survives.

Configuration
REQ-023 Macro SAL_ACT_ARB_FAW_EN defined: 4 tFAW slot timers; handshake loads a free slot with max(tfaw_i-2,0), slot free at 0; at most 4 handshakes in any tfaw_i-cycle window, 5th handshake >= first + tfaw_i.
REQ-024 Macro undefined: no slot timers synthesized, tfaw_i ignored, slot-free condition constant true.

Structure
REQ-025 Shared package SAL_ACT_PKG SHALL hold FSM state enum and FAW_ACT_LIMIT=4.
REQ-026 Round-robin pick SHALL be sub-module SAL_RR_ARB (inputs req, ptr; outputs valid, index), purely combinational.

Verification
REQ-027 trrd_i=4, tfaw_i=32, req_i=4'b0101 constant, act_ready_i=1 -> grants bank0, bank2, bank0 with handshakes exactly 4 cycles apart.
REQ-028 FAW_EN, trrd_i=2, tfaw_i=20, req_i=4'b1111, ready=1 -> handshakes at t, t+2, t+4, t+6, 5th at t+20; order 0,1,2,3,0.
REQ-029 Single req_i[3], act_ready_i low 5 cycles -> act_valid_o=1, act_bk_o=3 stable 5 cycles, gnt_o=4'b1000 only in handshake cycle.
REQ-030 rst pulsed while HOLD with act_bk_o=2 -> act_valid_o=0 immediately, gnt_o never pulses, next grant from ptr=0.
REQ-031 trrd_i=0, back-to-back reqs -> spacing exactly 2 cycles; FAW_EN undefined, tfaw_i=63 -> no extra stall after 4 ACTs.
